dac_batch_source: RTL and testbench

AXI-Stream transmitter that generates 256-bit DAC sample batches (16 lanes × 16-bit) as an arithmetic ramp. It drives the same stream interface that the DAC-side splitter receives, and serves as the on-chip pattern source for DAC bring-up and loopback tests. It runs a configured number of batches, or runs continuously, and honours tready backpressure.

---
 rtl/dac_batch_pkg.sv | 20 ++
 rtl/dac_batch_lane.sv | 51 +++++
 rtl/dac_batch_source.sv | 140 ++++++++++++++
 tb/tb_dac_batch_source.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_batch_pkg.sv
`default_nettype none
// ============================================================================
// dac_batch_pkg : shared constants and state encoding for the DAC ramp source
// Revision 1.0
// ============================================================================
package dac_batch_pkg;

   localparam int c_DATAW   = 256;
   localparam int c_SAMPLEW = 16;
   localparam int c_SAMPLES = c_DATAW / c_SAMPLEW;
   localparam int c_CNTW    = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/dac_batch_lane.sv
`default_nettype none
// ============================================================================
// dac_batch_lane : one ramp sample lane, loaded with start + LANE_IDX*step and
//                  advanced by step << ADV_SHIFT on every accepted batch
// Revision 1.0
// ============================================================================
module dac_batch_lane #(
   parameter int SAMPLEW   = 16,
   parameter int LANE_IDX  = 0,
   parameter int ADV_SHIFT = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               advance,
   input  logic [SAMPLEW-1:0] start_val,
   input  logic [SAMPLEW-1:0] load_step,
   input  logic [SAMPLEW-1:0] run_step,
   output logic [SAMPLEW-1:0] sample
);

   logic [SAMPLEW-1:0] w_offset;
   logic [SAMPLEW-1:0] w_adv_val;
   logic [SAMPLEW-1:0] r_sample;

   // LANE_IDX is a constant, so this reduces to a fixed shift-add tree
   always_comb begin
      w_offset = '0;
      for (int b = 0; b < 16; b++) begin
         if (((LANE_IDX >> b) & 1) != 0) begin
            w_offset = w_offset + (load_step << b);
         end
      end
   end

   assign w_adv_val = r_sample + (run_step << ADV_SHIFT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sample <= '0;
      end else if (load) begin
         r_sample <= start_val + w_offset;
      end else if (advance) begin
         r_sample <= w_adv_val;
      end
   end

   assign sample = r_sample;

endmodule
`default_nettype wire

// File: rtl/dac_batch_source.sv
`default_nettype none
// ============================================================================
// dac_batch_source : AXI-Stream ramp generator producing 16x16-bit DAC batches
// Revision 1.0
// ============================================================================
module dac_batch_source
   import dac_batch_pkg::*;
#(
   parameter int DATAW   = c_DATAW,
   parameter int SAMPLEW = c_SAMPLEW,
   parameter int CNTW    = c_CNTW
) (
   input  logic               m_axis_aclk,
   input  logic               rst,
   input  logic               start,
   input  logic               halt,
   input  logic [SAMPLEW-1:0] cfg_start_val,
   input  logic [SAMPLEW-1:0] cfg_step,
   input  logic [CNTW-1:0]    cfg_num_batches,
   output logic               M_AXIS_tvalid,
   input  logic               M_AXIS_tready,
   output logic [DATAW-1:0]   M_AXIS_tdata,
   output logic               M_AXIS_tlast,
   output logic               busy,
   output logic               done,
   output logic [CNTW-1:0]    batch_count
);

   localparam int            SAMPLES     = DATAW / SAMPLEW;
   localparam int            c_ADV_SHIFT = $clog2(SAMPLES);
   localparam logic [CNTW-1:0] c_ONE     = CNTW'(1);
   localparam logic [CNTW-1:0] c_MAX     = '1;

   state_t             r_state;
   logic [SAMPLEW-1:0] r_step;
   logic [CNTW-1:0]    r_num;
   logic [CNTW-1:0]    r_count;
   logic               r_tvalid;
   logic               r_tlast;
   logic               r_busy;
   logic               r_done;

   logic               w_load;
   logic               w_xfer;
   logic               w_finite;
   logic               w_last;
   logic               w_next_last;
   logic [CNTW-1:0]    w_count_inc;

   assign w_load      = (r_state == IDLE) && start;
   assign w_xfer      = r_tvalid && M_AXIS_tready;
   assign w_count_inc = (r_count == c_MAX) ? r_count : r_count + c_ONE;
   assign w_finite    = (r_num != '0);
   assign w_last      = w_finite && (w_count_inc == r_num);
   // tlast for the batch that follows the one being accepted now
   assign w_next_last = w_finite && ((w_count_inc + c_ONE) == r_num);

   generate
      for (genvar i = 0; i < SAMPLES; i++) begin : g_lane
         dac_batch_lane #(
            .SAMPLEW  (SAMPLEW),
            .LANE_IDX (i),
            .ADV_SHIFT(c_ADV_SHIFT)
         ) u_lane (
            .clk      (m_axis_aclk),
            .rst      (rst),
            .load     (w_load),
            .advance  (w_xfer),
            .start_val(cfg_start_val),
            .load_step(cfg_step),
            .run_step (r_step),
            .sample   (M_AXIS_tdata[SAMPLEW*i +: SAMPLEW])
         );
      end
   endgenerate

   always_ff @(posedge m_axis_aclk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_step   <= '0;
         r_num    <= '0;
         r_count  <= '0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_step   <= cfg_step;
                  r_num    <= cfg_num_batches;
                  r_count  <= '0;
                  r_tvalid <= 1'b1;
                  r_tlast  <= (cfg_num_batches == c_ONE);
                  r_busy   <= 1'b1;
                  r_state  <= RUN;
               end
            end
            RUN: begin
               if (w_xfer) begin
                  r_count <= w_count_inc;
                  if (w_last || halt) begin
                     r_tvalid <= 1'b0;
                     r_tlast  <= 1'b0;
                     r_busy   <= 1'b0;
                     r_done   <= 1'b1;
                     r_state  <= IDLE;
                  end else begin
                     r_tlast <= w_next_last;
                  end
               end else if (halt) begin
                  // a stalled batch must still be delivered before stopping
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (w_xfer) begin
                  r_count  <= w_count_inc;
                  r_tvalid <= 1'b0;
                  r_tlast  <= 1'b0;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign M_AXIS_tvalid = r_tvalid;
   assign M_AXIS_tlast  = r_tlast;
   assign busy          = r_busy;
   assign done          = r_done;
   assign batch_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_dac_batch_source.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_dac_batch_source : scoreboard bench for the DAC ramp batch source
// Revision 1.0
// ============================================================================
module tb_dac_batch_source;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         halt = 1'b0;
   logic         tready = 1'b0;
   logic [15:0]  cfg_start_val = '0;
   logic [15:0]  cfg_step = '0;
   logic [31:0]  cfg_num_batches = '0;
   logic         tvalid;
   logic         tlast;
   logic         busy;
   logic         done;
   logic [255:0] tdata;
   logic [31:0]  batch_count;

   always #5 clk = ~clk;

   dac_batch_source dut (
      .m_axis_aclk    (clk),
      .rst            (rst),
      .start          (start),
      .halt           (halt),
      .cfg_start_val  (cfg_start_val),
      .cfg_step       (cfg_step),
      .cfg_num_batches(cfg_num_batches),
      .M_AXIS_tvalid  (tvalid),
      .M_AXIS_tready  (tready),
      .M_AXIS_tdata   (tdata),
      .M_AXIS_tlast   (tlast),
      .busy           (busy),
      .done           (done),
      .batch_count    (batch_count)
   );

   typedef struct packed {
      logic [255:0] d;
      logic         l;
   } exp_t;

   exp_t         exp_q[$];
   logic [255:0] xfer_log[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int xfer_cnt = 0;
   int done_cnt = 0;
   int xfer_cyc = 0;
   int done_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [255:0] model_batch(input logic [15:0] s, input logic [15:0] d, input int k);
      logic [255:0] r;
      for (int i = 0; i < 16; i++) r[16*i +: 16] = s + 16'((16*k + i) * d);
      return r;
   endfunction

   task automatic push_run(input logic [15:0] s, input logic [15:0] d, input int first, input int count, input int n);
      exp_t e;
      for (int k = first; k < first + count; k++) begin
         e.d = model_batch(s, d, k);
         e.l = (n != 0) && (k == n - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic pulse_start(input logic [15:0] s, input logic [15:0] d, input logic [31:0] n, input bit with_halt);
      @(posedge clk); #1;
      cfg_start_val = s; cfg_step = d; cfg_num_batches = n;
      start = 1'b1; halt = with_halt;
      @(posedge clk); #1;
      start = 1'b0; halt = 1'b0;
   endtask

   task automatic wait_done(input int base, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_cnt > base) begin ok = 1'b1; break; end
      end
      @(negedge clk);
   endtask

   // Scoreboard: every visible batch must match the head of the queue
   always @(negedge clk) begin
      if (!rst) begin
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (tvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_batch data=%h last=%b", tdata, tlast);
            end else begin
               if (tdata !== exp_q[0].d || tlast !== exp_q[0].l) begin
                  errors++;
                  $display("FAIL batch_%s got data=%h last=%b exp data=%h last=%b",
                           tready ? "xfer" : "stall", tdata, tlast, exp_q[0].d, exp_q[0].l);
               end
               if (tready) begin
                  xfer_log.push_back(tdata);
                  void'(exp_q.pop_front());
                  xfer_cnt++;
                  xfer_cyc = cyc;
               end
            end
         end
      end
   end

   task automatic test_reset();
      @(negedge clk);
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", tvalid); end
      checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b exp 0", tlast); end
      checks++; if (tdata !== '0) begin errors++; $display("FAIL reset_tdata got %h exp 0", tdata); end
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done got %b exp 00", {busy, done}); end
      checks++; if (batch_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", batch_count); end
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic test_basic();
      int base_d = done_cnt; int base_x = xfer_cnt; bit ok;
      xfer_log.delete();
      tready = 1'b1;
      push_run(16'h0000, 16'h0001, 0, 3, 3);
      @(posedge clk); #1;
      cfg_start_val = 16'h0000; cfg_step = 16'h0001; cfg_num_batches = 32'd3; start = 1'b1;
      @(negedge clk);
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL basic_latency0 got %b exp 0", tvalid); end
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      checks++; if ({tvalid, busy} !== 2'b11) begin errors++; $display("FAIL basic_latency1 got %b exp 11", {tvalid, busy}); end
      wait_done(base_d, 50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout got 0 exp 1"); end
      checks++; if (xfer_cnt - base_x != 3) begin errors++; $display("FAIL basic_xfers got %0d exp 3", xfer_cnt - base_x); end
      checks++; if (done_cyc != xfer_cyc + 1) begin errors++; $display("FAIL basic_done_timing got %0d exp %0d", done_cyc, xfer_cyc + 1); end
      checks++; if (batch_count !== 32'd3) begin errors++; $display("FAIL basic_count got %0d exp 3", batch_count); end
      checks++; if (xfer_log.size() != 3 || xfer_log[2][15:0] !== 16'd32 || xfer_log[2][255:240] !== 16'd47) begin
         errors++; $display("FAIL basic_batch2_lanes got n=%0d exp lane0=32 lane15=47", xfer_log.size());
      end
      tready = 1'b0;
   endtask

   task automatic test_backpressure();
      int base_d = done_cnt; int base_x = xfer_cnt;
      logic [3:0] pat = 4'b1001;
      tready = 1'b0;
      push_run(16'h0000, 16'h0001, 0, 3, 3);
      pulse_start(16'h0000, 16'h0001, 32'd3, 1'b0);
      for (int i = 0; i < 200 && done_cnt == base_d; i++) begin
         tready = pat[i % 4];
         @(posedge clk); #1;
      end
      tready = 1'b0;
      checks++; if (done_cnt == base_d) begin errors++; $display("FAIL bp_done_timeout got 0 exp 1"); end
      checks++; if (xfer_cnt - base_x != 3) begin errors++; $display("FAIL bp_xfers got %0d exp 3", xfer_cnt - base_x); end
      checks++; if (batch_count !== 32'd3) begin errors++; $display("FAIL bp_count got %0d exp 3", batch_count); end
   endtask

   task automatic test_wrap();
      int base_d = done_cnt; bit ok;
      xfer_log.delete();
      tready = 1'b1;
      push_run(16'hFFF0, 16'h0001, 0, 2, 2);
      pulse_start(16'hFFF0, 16'h0001, 32'd2, 1'b0);
      wait_done(base_d, 50, ok);
      tready = 1'b0;
      checks++; if (!ok) begin errors++; $display("FAIL wrap_done_timeout got 0 exp 1"); end
      checks++; if (xfer_log.size() != 2 || xfer_log[0][255:240] !== 16'hFFFF || xfer_log[1][15:0] !== 16'h0000
                    || xfer_log[1][255:240] !== 16'h000F) begin
         errors++; $display("FAIL wrap_lanes got n=%0d exp FFFF/0000/000F", xfer_log.size());
      end
   endtask

   task automatic test_halt();
      int base_d = done_cnt; int base_x = xfer_cnt; bit ok;
      tready = 1'b0;
      push_run(16'h0010, 16'h0002, 0, 5, 0);
      pulse_start(16'h0010, 16'h0002, 32'd0, 1'b0);
      tready = 1'b1;
      repeat (4) @(posedge clk);
      #1 halt = 1'b1;
      @(posedge clk); #1 halt = 1'b0; tready = 1'b0;
      wait_done(base_d, 20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL halt_done_timeout got 0 exp 1"); end
      checks++; if (xfer_cnt - base_x != 5) begin errors++; $display("FAIL halt_xfers got %0d exp 5", xfer_cnt - base_x); end
      checks++; if (done_cyc != xfer_cyc + 1) begin errors++; $display("FAIL halt_done_timing got %0d exp %0d", done_cyc, xfer_cyc + 1); end
      checks++; if (batch_count !== 32'd5) begin errors++; $display("FAIL halt_count got %0d exp 5", batch_count); end
      checks++; if ({tvalid, busy} !== 2'b00) begin errors++; $display("FAIL halt_idle got %b exp 00", {tvalid, busy}); end
   endtask

   task automatic test_drain();
      int base_d = done_cnt; bit ok;
      tready = 1'b0;
      push_run(16'h0000, 16'h0002, 0, 3, 0);
      pulse_start(16'h0000, 16'h0002, 32'd0, 1'b0);
      tready = 1'b1;
      repeat (2) @(posedge clk);
      #1 tready = 1'b0; halt = 1'b1;
      @(posedge clk); #1 halt = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if ({busy, tvalid} !== 2'b11 || done_cnt != base_d) begin
         errors++; $display("FAIL drain_hold got busy,tvalid=%b dones=%0d exp 11 0", {busy, tvalid}, done_cnt - base_d);
      end
      checks++; if (batch_count !== 32'd2) begin errors++; $display("FAIL drain_count_hold got %0d exp 2", batch_count); end
      @(posedge clk); #1 tready = 1'b1;
      @(posedge clk); #1 tready = 1'b0;
      wait_done(base_d, 20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL drain_done_timeout got 0 exp 1"); end
      checks++; if (done_cyc != xfer_cyc + 1) begin errors++; $display("FAIL drain_done_timing got %0d exp %0d", done_cyc, xfer_cyc + 1); end
      checks++; if (batch_count !== 32'd3) begin errors++; $display("FAIL drain_count got %0d exp 3", batch_count); end
   endtask

   task automatic test_reset_midrun();
      int base_d = done_cnt; bit ok;
      tready = 1'b0;
      push_run(16'h0100, 16'h0003, 0, 3, 0);
      pulse_start(16'h0100, 16'h0003, 32'd0, 1'b0);
      tready = 1'b1;
      repeat (2) @(posedge clk);
      #1 tready = 1'b0;
      @(negedge clk);
      checks++; if (batch_count !== 32'd2) begin errors++; $display("FAIL rstmid_pre_count got %0d exp 2", batch_count); end
      #2 rst = 1'b1;
      #1;
      checks++; if ({tvalid, busy} !== 2'b00) begin errors++; $display("FAIL rstmid_async got %b exp 00", {tvalid, busy}); end
      checks++; if (batch_count !== 32'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", batch_count); end
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (done_cnt != base_d) begin errors++; $display("FAIL rstmid_no_done got %0d exp 0", done_cnt - base_d); end
      tready = 1'b1;
      push_run(16'h0100, 16'h0003, 0, 2, 2);
      pulse_start(16'h0100, 16'h0003, 32'd2, 1'b0);
      wait_done(base_d, 50, ok);
      tready = 1'b0;
      checks++; if (!ok || batch_count !== 32'd2) begin errors++; $display("FAIL rstmid_restart got done=%b count=%0d exp 1 2", ok, batch_count); end
   endtask

   task automatic test_single_and_busy_start();
      int base_d = done_cnt; int base_x = xfer_cnt; bit ok;
      tready = 1'b0;
      push_run(16'h4000, 16'h0011, 0, 1, 1);
      pulse_start(16'h4000, 16'h0011, 32'd1, 1'b1);
      @(posedge clk); #1;
      cfg_start_val = 16'hAAAA; cfg_step = 16'h0005; cfg_num_batches = 32'd7; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #1 tready = 1'b1;
      wait_done(base_d, 20, ok);
      tready = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (!ok) begin errors++; $display("FAIL single_done_timeout got 0 exp 1"); end
      checks++; if (xfer_cnt - base_x != 1) begin errors++; $display("FAIL single_xfers got %0d exp 1", xfer_cnt - base_x); end
      checks++; if (batch_count !== 32'd1) begin errors++; $display("FAIL single_count got %0d exp 1", batch_count); end
      checks++; if (done_cyc != xfer_cyc + 1) begin errors++; $display("FAIL single_done_timing got %0d exp %0d", done_cyc, xfer_cyc + 1); end
      checks++; if ({tvalid, busy} !== 2'b00 || exp_q.size() != 0) begin
         errors++; $display("FAIL single_idle got %b pending=%0d exp 00 0", {tvalid, busy}, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_halt();
      test_drain();
      test_reset_midrun();
      test_single_and_busy_start();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
